// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over req/ready, presents one instruction at a time.
// Throughput is one instruction per two cycles at best; a stalled instruction is held until downstream takes it.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  input  logic        pc_enable,
  input  logic [1:0]  jump_mux_signal,
  input  logic [31:0] im_data,
  input  logic [31:0] jump_reg_value,
  input  logic        branch_taken,
  input  logic        stall,
  output logic        halted,
  output logic        fetch_error
);

  typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic        req_q, req_nxt;
  logic        halt_q, halt_nxt;
  logic        err_q, err_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic [31:0] seq_pc, target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr_q  <= instr_nxt;
      req_q    <= req_nxt;
      halt_q   <= halt_nxt;
      err_q    <= err_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    seq_pc = pc + 32'd4;
    target = seq_pc;
    case (jump_mux_signal)
      2'd0: target = seq_pc;
      2'd1: target = branch_taken ? (seq_pc + (im_data << 2)) : seq_pc;
      2'd2: target = jump_reg_value;
      2'd3: target = {pc[31:18], im_data[15:0], 2'b00};
      default: target = seq_pc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    req_nxt   = req_q;
    halt_nxt  = halt_q;
    err_nxt   = err_q;
    wait_nxt  = wait_cnt;
    case (state)
      FETCH: begin
        // The cycle right after reset release only raises the request.
        if (!req_q) begin
          req_nxt = 1'b1;
        end else if (imem_ready) begin
          instr_nxt = imem_rdata;
          wait_nxt  = '0;
          req_nxt   = 1'b0;
          state_nxt = ISSUE;
        end else if (wait_cnt == WAIT_LAST) begin
          err_nxt   = 1'b1;
          halt_nxt  = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = HALT;
        end else begin
          wait_nxt = wait_cnt + 16'd1;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (!pc_enable) begin
            halt_nxt  = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt    = target & ~32'd3;
            req_nxt   = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      HALT: begin
        req_nxt = 1'b0;
      end
      default: begin
        state_nxt = HALT;
        req_nxt   = 1'b0;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc;
  assign pc_out      = pc;
  assign instruction = instr_q;
  assign instr_valid = (state == ISSUE);
  assign halted      = halt_q;
  assign fetch_error = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table of retire vectors plus stall, halt, timeout and reset sequences.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic        pc_enable;
  logic [1:0]  jump_mux_signal;
  logic [31:0] im_data;
  logic [31:0] jump_reg_value;
  logic        branch_taken;
  logic        stall;
  logic        halted;
  logic        fetch_error;

  int tests = 0;
  int fails = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .pc_out(pc_out), .pc_enable(pc_enable),
    .jump_mux_signal(jump_mux_signal), .im_data(im_data), .jump_reg_value(jump_reg_value),
    .branch_taken(branch_taken), .stall(stall), .halted(halted), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  mode;
    logic [31:0] imm;
    logic [31:0] regv;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] next_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
    pc_enable = 1'b1; jump_mux_signal = 2'd0; im_data = '0; jump_reg_value = '0; branch_taken = 1'b0;
    step();
    step();
  endtask

  // From a FETCH cycle with request up: answer immediately, check the ISSUE view, set retire inputs.
  task automatic fetch_and_present(input string tag, input logic [31:0] pc, input logic [31:0] word);
    chk({tag, ".req"}, 32'(imem_req), 32'd1);
    chk({tag, ".addr"}, imem_addr, pc);
    chk({tag, ".vld_fetch"}, 32'(instr_valid), 32'd0);
    imem_ready = 1'b1; imem_rdata = word;
    step();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    chk({tag, ".vld"}, 32'(instr_valid), 32'd1);
    chk({tag, ".instr"}, instruction, word);
    chk({tag, ".pc_out"}, pc_out, pc);
    chk({tag, ".req_issue"}, 32'(imem_req), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'hA000_0001, 2'd0, 32'h0,         32'h0,         1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{32'hA000_0002, 2'd0, 32'h0,         32'h0,         1'b0, 32'h0000_0004, 32'h0000_0008};
    vecs[2]  = '{32'hA000_0003, 2'd2, 32'h0,         32'h0000_0013, 1'b0, 32'h0000_0008, 32'h0000_0010};
    vecs[3]  = '{32'hA000_0004, 2'd1, 32'hFFFF_FFFE, 32'h0,         1'b1, 32'h0000_0010, 32'h0000_000C};
    vecs[4]  = '{32'hA000_0005, 2'd0, 32'h0,         32'h0,         1'b0, 32'h0000_000C, 32'h0000_0010};
    vecs[5]  = '{32'hA000_0006, 2'd1, 32'hFFFF_FFFE, 32'h0,         1'b0, 32'h0000_0010, 32'h0000_0014};
    vecs[6]  = '{32'hA000_0007, 2'd2, 32'h0,         32'h0000_1003, 1'b0, 32'h0000_0014, 32'h0000_1000};
    vecs[7]  = '{32'hA000_0008, 2'd2, 32'h0,         32'h8004_0000, 1'b0, 32'h0000_1000, 32'h8004_0000};
    vecs[8]  = '{32'hA000_0009, 2'd3, 32'h0000_0012, 32'h0,         1'b0, 32'h8004_0000, 32'h8004_0048};
    vecs[9]  = '{32'hA000_000A, 2'd2, 32'h0,         32'hFFFF_FFFC, 1'b0, 32'h8004_0048, 32'hFFFF_FFFC};
    vecs[10] = '{32'hA000_000B, 2'd0, 32'h0,         32'h0,         1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[11] = '{32'hA000_000C, 2'd1, 32'h0000_0003, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0010};

    do_reset();
    chk("rst.req", 32'(imem_req), 32'd0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.vld", 32'(instr_valid), 32'd0);
    chk("rst.instr", instruction, 32'h0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.err", 32'(fetch_error), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      fetch_and_present($sformatf("v%0d", i), vecs[i].pc, vecs[i].word);
      pc_enable = 1'b1; jump_mux_signal = vecs[i].mode; im_data = vecs[i].imm;
      jump_reg_value = vecs[i].regv; branch_taken = vecs[i].taken;
      step();
      chk($sformatf("v%0d.next", i), imem_addr, vecs[i].next_pc);
      chk($sformatf("v%0d.vld_after", i), 32'(instr_valid), 32'd0);
    end

    // Stall three cycles while memory wrongly signals ready; nothing may move.
    fetch_and_present("stall", 32'h10, 32'h1234_5678);
    stall = 1'b1; jump_mux_signal = 2'd0; imem_ready = 1'b1; imem_rdata = 32'h5555_5555;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall.vld", 32'(instr_valid), 32'd1);
      chk("stall.instr", instruction, 32'h1234_5678);
      chk("stall.pc", pc_out, 32'h10);
      chk("stall.req", 32'(imem_req), 32'd0);
    end
    imem_ready = 1'b0; stall = 1'b0;
    step();
    chk("stall.release", imem_addr, 32'h14);

    // Halt opcode: PC holds and no further requests.
    fetch_and_present("halt", 32'h14, 32'h0);
    pc_enable = 1'b0; jump_mux_signal = 2'd2; jump_reg_value = 32'h4000;
    step();
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.vld", 32'(instr_valid), 32'd0);
    chk("halt.pc", pc_out, 32'h14);
    imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("halt.req", 32'(imem_req), 32'd0);
      chk("halt.hold", 32'(halted), 32'd1);
    end
    do_reset();
    chk("rehalt.halted", 32'(halted), 32'd0);
    chk("rehalt.pc", pc_out, 32'h0);
    rst_n = 1'b1;
    step();
    chk("rehalt.req", 32'(imem_req), 32'd1);

    // Timeout: four unanswered request cycles.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("to.req", 32'(imem_req), 32'd1);
      chk("to.err_early", 32'(fetch_error), 32'd0);
    end
    step();
    chk("to.err", 32'(fetch_error), 32'd1);
    chk("to.halted", 32'(halted), 32'd1);
    chk("to.req_off", 32'(imem_req), 32'd0);
    do_reset();
    chk("to.rst_err", 32'(fetch_error), 32'd0);
    chk("to.rst_halted", 32'(halted), 32'd0);

    // Ready on the limit edge wins with no error.
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_0001;
    step();
    imem_ready = 1'b0;
    chk("lim.err", 32'(fetch_error), 32'd0);
    chk("lim.vld", 32'(instr_valid), 32'd1);
    chk("lim.instr", instruction, 32'hCAFE_0001);

    // Reset asserted mid-fetch.
    stall = 1'b0; pc_enable = 1'b1; jump_mux_signal = 2'd0;
    step();
    chk("mid.req_before", 32'(imem_req), 32'd1);
    chk("mid.addr_before", imem_addr, 32'h4);
    rst_n = 1'b0;
    step();
    chk("mid.req", 32'(imem_req), 32'd0);
    chk("mid.addr", imem_addr, 32'h0);
    chk("mid.err", 32'(fetch_error), 32'd0);
    chk("mid.halted", 32'(halted), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
